// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and default memory depth for the load/store initiator
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int DEF_MEM_WORDS = 64;
  typedef enum logic [2:0] {IDLE, RD, CAP, MERGE, WR, RESP} state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extraction/extension for loads and lane merge for sub-word stores
module lsu_lane_align (
  input  logic [31:0] word_in,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [1:0]  eff;
  logic [31:0] sh, ws, mask;
  // word ignores the lane, half uses only addr[1]; size 11 falls into the word branch
  always_comb begin
    eff = size[1] ? 2'b00 : size[0] ? {lane[1], 1'b0} : lane;
    sh = word_in >> {eff, 3'b000};
    ws = wdata << {eff, 3'b000};
    mask = (size[1] ? 32'hFFFF_FFFF : size[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {eff, 3'b000};
    load_data = size[1] ? sh : size[0] ? {{16{~uns & sh[15]}}, sh[15:0]} : {{24{~uns & sh[7]}}, sh[7:0]};
    merged = (word_in & ~mask) | (ws & mask);
  end
endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: load/store initiator to a word-addressed sync memory; LSU_ADDR_CHECK_EN enables alignment/range rejection
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  input  logic [31:0] Read_data
);
  state_t      state_q, state_d;
  logic        acc, err, we_q, uns_q;
  logic [1:0]  size_q, lane_q;
  logic [29:0] idx;
  logic [31:0] wdata_q, load_data, merged;
  assign acc = req_valid && req_ready;
`ifdef LSU_ADDR_CHECK_EN
  assign err = (req_size == SZ_HALF && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00) ||
               (req_addr[31:2] >= 30'(MEM_WORDS));
  assign idx = req_addr[31:2];
`else
  assign err = 1'b0;
  assign idx = req_addr[31:2] % 30'(MEM_WORDS);
`endif
  lsu_lane_align u_align (
    .word_in  (Read_data),
    .wdata    (wdata_q),
    .lane     (lane_q),
    .size     (size_q),
    .uns      (uns_q),
    .load_data(load_data),
    .merged   (merged)
  );
  // state register; reset drops the strobes immediately since they decode the state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state and decoded handshake/strobe outputs
  always_comb begin
    state_d = state_q;
    req_ready = state_q == IDLE;
    rsp_valid = state_q == RESP;
    MemRead = state_q == RD;
    MemWrite = state_q == WR;
    case (state_q)
      IDLE:    if (acc) state_d = err ? RESP : (req_we && req_size[1]) ? WR : RD;
      RD:      state_d = we_q ? MERGE : CAP;
      CAP:     state_d = RESP;
      MERGE:   state_d = WR;
      WR:      state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // request latch, memory port registers and response registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      we_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= SZ_BYTE;
      lane_q <= 2'b00;
      wdata_q <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      Address <= '0;
      Write_data <= '0;
    end else begin
      if (acc) begin
        we_q <= req_we;
        uns_q <= req_unsigned;
        size_q <= req_size;
        lane_q <= req_addr[1:0];
        wdata_q <= req_wdata;
        rsp_rdata <= '0;
        rsp_err <= err;
        if (!err) Address <= {2'b00, idx};
        if (!err && req_we && req_size[1]) Write_data <= req_wdata;
      end
      if (state_q == CAP) rsp_rdata <= load_data;
      if (state_q == MERGE) Write_data <= merged;
    end
  end
endmodule
